// File: rtl/aes_pkg.sv
// Shared AES definitions for the cipher round core: S-box, FSM states,
// supported round counts and the GF(2^8) xtime helper.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_KEY,
        APPLY,
        DONE
    } fsm_state_t;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/cipher_round_fn.sv
// Combinational AES round: key whitening on the first round, full round in
// the middle, MixColumns skipped on the last round.
module cipher_round_fn
    import aes_pkg::*;
(
    input  logic [0:127] state_i,
    input  logic [0:127] key_i,
    input  logic         first_i,
    input  logic         last_i,
    output logic [0:127] state_o
);

    logic [0:127] sr_v;
    logic [0:127] mc_v;
    logic [7:0]   s0, s1, s2, s3;

    // Byte r of column c sits at bit 32*c + 8*r; ShiftRows pulls row r from column c+r.
    always_comb begin
        sr_v = '0;
        mc_v = '0;
        s0   = '0;
        s1   = '0;
        s2   = '0;
        s3   = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            s0 = SBOX[state_i[32*c +: 8]];
            s1 = SBOX[state_i[32*((c+1) % 4) + 8 +: 8]];
            s2 = SBOX[state_i[32*((c+2) % 4) + 16 +: 8]];
            s3 = SBOX[state_i[32*((c+3) % 4) + 24 +: 8]];
            sr_v[32*c +: 32] = {s0, s1, s2, s3};
            mc_v[32*c +: 32] = {
                xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
                s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
                s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
                xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)
            };
        end
    end

    always_comb begin
        if (first_i) begin
            state_o = state_i ^ key_i;
        end else if (last_i) begin
            state_o = sr_v ^ key_i;
        end else begin
            state_o = mc_v ^ key_i;
        end
    end

endmodule

// File: rtl/cipher_round_core.sv
// Iterative AES encryption core fed one round key at a time by an external
// key-expansion stage. Optional key-wait timeout: CIPHER_KEY_TIMEOUT_EN.
module cipher_round_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         DataValid,
    input  logic [0:127] PlainText,
    input  logic [3:0]   Nr,
    input  logic [0:127] ExpandedKey,
    input  logic         KeyReady,
    output logic         KeyEncEN,
    output logic [3:0]   Round,
    output logic         EncFinish,
    output logic [0:127] CipherText,
    output logic         Busy
`ifdef CIPHER_KEY_TIMEOUT_EN
    ,
    output logic         KeyTimeout
`endif
);

    fsm_state_t   fsm_q;
    logic [0:127] block_q;
    logic [0:127] key_q;
    logic [3:0]   nr_q;
    logic [3:0]   round_q;
    logic         keyen_q;
    logic         finish_q;
    logic [0:127] ct_q;
    logic         busy_q;
    logic [0:127] block_d;
    logic [3:0]   nr_d;

`ifdef CIPHER_KEY_TIMEOUT_EN
    logic [4:0]   wait_cnt_q;
    logic         timeout_q;
    assign KeyTimeout = timeout_q;
`endif

    assign nr_d = (Nr == NR_192 || Nr == NR_256) ? Nr : NR_128;

    cipher_round_fn u_round (
        .state_i (block_q),
        .key_i   (key_q),
        .first_i (round_q == 4'd0),
        .last_i  (round_q == nr_q),
        .state_o (block_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q    <= IDLE;
            block_q  <= '0;
            key_q    <= '0;
            nr_q     <= NR_128;
            round_q  <= '0;
            keyen_q  <= 1'b0;
            finish_q <= 1'b0;
            ct_q     <= '0;
            busy_q   <= 1'b0;
`ifdef CIPHER_KEY_TIMEOUT_EN
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
`ifdef CIPHER_KEY_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (fsm_q)
                IDLE: begin
                    if (DataValid) begin
                        block_q <= PlainText;
                        nr_q    <= nr_d;
                        round_q <= '0;
                        keyen_q <= 1'b1;
                        busy_q  <= 1'b1;
                        fsm_q   <= WAIT_KEY;
`ifdef CIPHER_KEY_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end
                end
                WAIT_KEY: begin
                    if (KeyReady) begin
                        key_q   <= ExpandedKey;
                        keyen_q <= 1'b0;
                        fsm_q   <= APPLY;
                    end
`ifdef CIPHER_KEY_TIMEOUT_EN
                    else if (wait_cnt_q == 5'd30) begin
                        timeout_q <= 1'b1;
                        keyen_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        fsm_q     <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 5'd1;
                    end
`endif
                end
                APPLY: begin
                    block_q <= block_d;
                    if (round_q == nr_q) begin
                        // CipherText loads the final block as DONE is entered, so
                        // EncFinish and the result appear together during DONE.
                        ct_q     <= block_d;
                        finish_q <= 1'b1;
                        fsm_q    <= DONE;
                    end else begin
                        round_q <= round_q + 4'd1;
                        keyen_q <= 1'b1;
                        fsm_q   <= WAIT_KEY;
`ifdef CIPHER_KEY_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end
                end
                DONE: begin
                    finish_q <= 1'b0;
                    busy_q   <= 1'b0;
                    fsm_q    <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign KeyEncEN   = keyen_q;
    assign Round      = round_q;
    assign EncFinish  = finish_q;
    assign CipherText = ct_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_cipher_round_core.sv
// Directed bench for cipher_round_core with a round-key feeder and a
// scoreboard of expected ciphertexts. Timeout checks need CIPHER_KEY_TIMEOUT_EN.
module tb_cipher_round_core;
    import aes_pkg::*;

    logic         clk;
    logic         rst;
    logic         DataValid;
    logic [0:127] PlainText;
    logic [3:0]   Nr;
    logic [0:127] ExpandedKey;
    logic         KeyReady;
    logic         KeyEncEN;
    logic [3:0]   Round;
    logic         EncFinish;
    logic [0:127] CipherText;
    logic         Busy;
`ifdef CIPHER_KEY_TIMEOUT_EN
    logic         KeyTimeout;
`endif

    cipher_round_core dut (
        .clk         (clk),
        .rst         (rst),
        .DataValid   (DataValid),
        .PlainText   (PlainText),
        .Nr          (Nr),
        .ExpandedKey (ExpandedKey),
        .KeyReady    (KeyReady),
        .KeyEncEN    (KeyEncEN),
        .Round       (Round),
        .EncFinish   (EncFinish),
        .CipherText  (CipherText),
        .Busy        (Busy)
`ifdef CIPHER_KEY_TIMEOUT_EN
        ,
        .KeyTimeout  (KeyTimeout)
`endif
    );

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           dv_cyc  = 0;
    int           en_rises = 0;
    int           en_rise_cyc = 0;
    int           fin_count = 0;
    logic         en_prev = 1'b0;
    logic [31:0]  ww [60];
    logic [127:0] rk128 [15];
    logic [127:0] rk256 [15];
    logic [127:0] exp_q [$];
    bit           rk_sel = 1'b0;
    bit           stray_en = 1'b0;
    logic [3:0]   hold_round = 4'd15;
    bit           seen_en = 1'b0;
    bit           served = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (KeyEncEN && !en_prev) begin
            en_rises++;
            en_rise_cyc = cyc;
        end
        en_prev = KeyEncEN;
        if (EncFinish) fin_count++;
    end

    // Key feeder: answers a request one cycle after KeyEncEN rises; optionally
    // follows each answer with a stray KeyReady while the core is applying it.
    initial begin
        KeyReady    = 1'b0;
        ExpandedKey = '0;
        forever begin
            @(posedge clk);
            #1;
            if (served && stray_en) begin
                KeyReady    = 1'b1;
                ExpandedKey = '1;
            end else begin
                KeyReady = 1'b0;
            end
            served = 1'b0;
            if (KeyEncEN && Round != hold_round) begin
                if (seen_en) begin
                    KeyReady    = 1'b1;
                    ExpandedKey = rk_sel ? rk256[Round] : rk128[Round];
                    served      = 1'b1;
                end
                seen_en = 1'b1;
            end else begin
                seen_en = 1'b0;
            end
        end
    end

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) begin
            if (i < nk) begin
                ww[i] = key[255 - 32*i -: 32];
            end else begin
                t = ww[i-1];
                if (i % nk == 0) begin
                    t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = xtime(rcon);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                ww[i] = ww[i-nk] ^ t;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [127:0] pt, input logic [3:0] nr, input bit big,
                         input logic [127:0] exp);
        @(negedge clk);
        rk_sel    = big;
        DataValid = 1'b1;
        PlainText = pt;
        Nr        = nr;
        dv_cyc    = cyc;
        exp_q.push_back(exp);
        @(negedge clk);
        DataValid = 1'b0;
        PlainText = '0;
    endtask

    task automatic wait_round(input string tag, input logic [3:0] r);
        for (int i = 0; i < 200 && Round !== r; i++) @(negedge clk);
        chk(tag, Round, r);
    endtask

    task automatic wait_finish(input string tag, input int exp_lat);
        int got;
        logic [127:0] exp;
        got = -1;
        for (int i = 0; i < 300 && got < 0; i++) begin
            @(negedge clk);
            if (EncFinish === 1'b1) got = cyc;
        end
        chk({tag, "_finish_seen"}, EncFinish, 1);
        if (got < 0) return;
        chk({tag, "_sb_entries"}, exp_q.size(), 1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        chk({tag, "_ct"}, CipherText, exp);
        chk({tag, "_latency"}, got - dv_cyc, exp_lat);
        chk({tag, "_busy_done"}, Busy, 1);
        @(negedge clk);
        chk({tag, "_finish_pulse"}, EncFinish, 0);
        chk({tag, "_busy_idle"}, Busy, 0);
        chk({tag, "_ct_held"}, CipherText, exp);
    endtask

    initial begin
        int fc;
        int en_base;
        rst       = 1'b0;
        DataValid = 1'b0;
        PlainText = '0;
        Nr        = 4'd10;

        expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        for (int r = 0; r < 15; r++)
            rk128[r] = (r <= 10) ? {ww[4*r], ww[4*r+1], ww[4*r+2], ww[4*r+3]} : '0;
        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        for (int r = 0; r < 15; r++)
            rk256[r] = {ww[4*r], ww[4*r+1], ww[4*r+2], ww[4*r+3]};

        repeat (3) @(negedge clk);
        chk("rst_keyen", KeyEncEN, 0);
        chk("rst_finish", EncFinish, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_round", Round, 0);
        chk("rst_ct", CipherText, 0);
        rst = 1'b1;

        // AES-128 known-answer block
        start(PT, 4'd10, 1'b0, CT128);
        chk("a128_busy_accept", Busy, 1);
        wait_finish("a128", 34);

        // AES-256 known-answer block; count key request phases
        en_base = en_rises;
        start(PT, 4'd14, 1'b1, CT256);
        wait_finish("a256", 46);
        chk("a256_key_phases", en_rises - en_base, 15);

        // Unsupported Nr falls back to 10 rounds
        start(PT, 4'd11, 1'b0, CT128);
        wait_finish("nr11", 34);

        // Stray DataValid mid-block and stray KeyReady during every APPLY
        stray_en = 1'b1;
        fc = fin_count;
        start(PT, 4'd10, 1'b0, CT128);
        wait_round("ign_round5", 4'd5);
        DataValid = 1'b1;
        PlainText = '1;
        Nr        = 4'd14;
        @(negedge clk);
        DataValid = 1'b0;
        PlainText = '0;
        wait_finish("ignored", 34);
        repeat (5) @(negedge clk);
        chk("ign_one_finish", fin_count - fc, 1);
        chk("ign_stays_idle", Busy, 0);
        stray_en = 1'b0;

        // Reset in round 7 abandons the block
        start(PT, 4'd10, 1'b0, CT128);
        wait_round("rst7_round", 4'd7);
        rst = 1'b0;
        #1;
        chk("rst7_busy", Busy, 0);
        chk("rst7_keyen", KeyEncEN, 0);
        chk("rst7_finish", EncFinish, 0);
        chk("rst7_round", Round, 0);
        chk("rst7_ct", CipherText, 0);
        exp_q.delete();
        fc = fin_count;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst7_no_finish", fin_count - fc, 0);
        start(PT, 4'd10, 1'b0, CT128);
        wait_finish("after_rst", 34);

`ifdef CIPHER_KEY_TIMEOUT_EN
        // Withhold the round-3 key until the core gives up
        hold_round = 4'd3;
        fc = fin_count;
        start(PT, 4'd10, 1'b0, CT128);
        for (int i = 0; i < 200 && KeyTimeout !== 1'b1; i++) @(negedge clk);
        chk("to_pulse", KeyTimeout, 1);
        chk("to_wait_cycles", cyc - en_rise_cyc, 31);
        chk("to_round", Round, 3);
        chk("to_ct_kept", CipherText, CT128);
        @(negedge clk);
        chk("to_pulse_end", KeyTimeout, 0);
        chk("to_busy_low", Busy, 0);
        chk("to_keyen_low", KeyEncEN, 0);
        chk("to_no_finish", fin_count - fc, 0);
        exp_q.delete();
        hold_round = 4'd15;
        start(PT, 4'd10, 1'b0, CT128);
        wait_finish("after_to", 34);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
